// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous
// value commit, leading-zero blanking, per-digit decimal points and blink.
module seg7_scan #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GHOST        = 2,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam int unsigned P_W   = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [P_W-1:0]    p_q, p_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  pend_val_q, pend_val_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic              pend_q, pend_d;
  logic [VAL_W-1:0]  act_val_q, act_val_d;
  logic [DIGITS-1:0] act_dp_q, act_dp_d;
  logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic              blk_ph_q, blk_ph_d;

  logic [6:0]        seg_q, seg_d;
  logic              seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_done_q, frame_done_d;

  logic              p_last;
  logic              idx_last;
  logic              wrap;
  logic [DIGITS-1:0] lz;
  logic              zero_run;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blank;
  logic              lit;

  // Active-high segment pattern, bit0 = a .. bit6 = g.
  function automatic logic [6:0] glyph_on(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Scan counters.
  always_comb begin
    p_last   = (p_q == P_W'(SCAN_DIV - 1));
    idx_last = (idx_q == IDX_W'(DIGITS - 1));
    wrap     = p_last && idx_last;
    p_d      = p_last ? '0 : p_q + P_W'(1);
    idx_d    = idx_q;
    if (p_last) begin
      idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Pending/active value path; a load in the wrap cycle bypasses pending.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_d     = pend_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    if (wrap) begin
      if (load) begin
        act_val_d = value;
        act_dp_d  = dp;
      end else if (pend_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp;
      pend_d     = 1'b1;
    end
  end

  // Blink phase toggles every BLINK_FRAMES frames.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    blk_ph_d  = blk_ph_q;
    if (wrap) begin
      if (blk_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blk_cnt_d = '0;
        blk_ph_d  = ~blk_ph_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end
  end

  // Leading-zero mask scanned from the top digit down; digit 0 always shown.
  always_comb begin
    lz       = '0;
    zero_run = blank_lz;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_val_q[4*i +: 4] == 4'h0);
      lz[i]    = zero_run && (i != 0);
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    lit       = (p_q >= P_W'(GHOST)) && !(blink_en && blk_ph_q);
    an_d      = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = act_val_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_blank = lz[i];
        an_d[i]   = ~lit;
      end
    end
    seg_d        = cur_blank ? 7'h7F : ~glyph_on(cur_nib);
    seg_dp_d     = ~(cur_dp && !cur_blank);
    frame_done_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q          <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_q       <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      blk_cnt_q    <= '0;
      blk_ph_q     <= 1'b0;
      seg_q        <= 7'h7F;
      seg_dp_q     <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      p_q          <= p_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_q       <= pend_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      blk_cnt_q    <= blk_cnt_d;
      blk_ph_q     <= blk_ph_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
